ndro_pulse_driver: RTL and testbench

Synchronous stimulus/check stage sitting directly upstream of basic_ndro. Converts a queued stream of commands (SET, RESET, READ, WAIT) into single-cycle pulses on the NDRO set/reset/clk inputs with guaranteed minimum spacing. Consumes the NDRO out line after each READ and compares it against an internal expected-state model. Used to build self-checking benches and VCDs for vcd_assert timing checks.

---
 rtl/ndro_pulse_driver.sv | 131 +++++++++++++
 tb/tb_ndro_pulse_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ndro_pulse_driver.sv
// Command-FIFO driven pulse sequencer for a basic NDRO cell: emits spaced set/reset/clk pulses,
// tracks the expected stored bit and checks each readout against it.
module ndro_pulse_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    output logic             ndro_set,
    output logic             ndro_reset,
    output logic             ndro_clk,
    input  logic             ndro_out,
    output logic             exp_state,
    output logic             busy,
    output logic [CNT_W-1:0] read_count,
    output logic [CNT_W-1:0] err_count,
    output logic             mismatch
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(GAP + 256) + 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, SLOT} state_t;
    typedef enum logic [1:0] {OP_WAIT = 2'b00, OP_SET = 2'b01, OP_RESET = 2'b10, OP_READ = 2'b11} op_t;

    logic [9:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    state_t           state_q;
    op_t              op_q;
    logic [LW-1:0]    slot_len_q, slot_cnt_q;
    logic             avail_q, obs_q, exp_q, mism_q;
    logic             set_q, rst_q, clk_q;
    logic [CNT_W-1:0] rd_cnt_q, err_cnt_q;

    logic push, pop, last, obs_d, read_bad;
    op_t  head_op;
    logic [7:0] head_arg;

    always_comb begin
        push     = cmd_valid && cmd_ready;
        last     = (state_q == SLOT) && (slot_cnt_q == slot_len_q);
        // From IDLE the pop waits for avail_q, a registered copy of non-empty, so a
        // fresh command reaches the pulse one cycle after its push edge plus one.
        pop      = (count_q != '0) && (((state_q == IDLE) && avail_q) || last);
        head_op  = op_t'(mem[rd_ptr_q][9:8]);
        head_arg = mem[rd_ptr_q][7:0];
        obs_d    = obs_q | ndro_out;
        read_bad = obs_d != exp_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {cmd_op, cmd_arg};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            op_q       <= OP_WAIT;
            slot_len_q <= '0;
            slot_cnt_q <= '0;
            avail_q    <= 1'b0;
            obs_q      <= 1'b0;
            exp_q      <= 1'b0;
            mism_q     <= 1'b0;
            set_q      <= 1'b0;
            rst_q      <= 1'b0;
            clk_q      <= 1'b0;
            rd_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            avail_q <= count_q != '0;
            set_q   <= 1'b0;
            rst_q   <= 1'b0;
            clk_q   <= 1'b0;

            if (state_q == SLOT && slot_cnt_q >= LW'(2)) obs_q <= obs_d;

            if (last && op_q == OP_READ) begin
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
                if (read_bad) begin
                    if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                    mism_q <= 1'b1;
                end
            end

            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                op_q       <= head_op;
                slot_len_q <= LW'(GAP) + ((head_op == OP_WAIT) ? LW'(head_arg) : '0);
                slot_cnt_q <= LW'(1);
                state_q    <= SLOT;
                obs_q      <= 1'b0;
                case (head_op)
                    OP_SET:   begin set_q <= 1'b1; exp_q <= 1'b1; end
                    OP_RESET: begin rst_q <= 1'b1; exp_q <= 1'b0; end
                    OP_READ:  clk_q <= 1'b1;
                    default:  ;
                endcase
            end else if (last) begin
                state_q <= IDLE;
            end else if (state_q == SLOT) begin
                slot_cnt_q <= slot_cnt_q + 1'b1;
            end
        end
    end

    assign cmd_ready  = count_q != FULL;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign ndro_set   = set_q;
    assign ndro_reset = rst_q;
    assign ndro_clk   = clk_q;
    assign exp_state  = exp_q;
    assign read_count = rd_cnt_q;
    assign err_count  = err_cnt_q;
    assign mismatch   = mism_q;
endmodule

// File: tb/tb_ndro_pulse_driver.sv
// Directed bench for ndro_pulse_driver: pulse timing, expected-state model, read checking,
// FIFO backpressure and asynchronous reset abort.
module tb_ndro_pulse_driver;
    localparam int unsigned GAP = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [7:0]  cmd_arg = '0;
    logic        ndro_set, ndro_reset, ndro_clk;
    logic        ndro_out = 1'b0;
    logic        exp_state, busy, mismatch;
    logic [15:0] read_count, err_count;

    ndro_pulse_driver #(.DEPTH(4), .GAP(GAP), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ndro_set(ndro_set), .ndro_reset(ndro_reset),
        .ndro_clk(ndro_clk), .ndro_out(ndro_out), .exp_state(exp_state), .busy(busy),
        .read_count(read_count), .err_count(err_count), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int viol = 0;
    int set_t[$], rst_t[$], clk_t[$];
    int exp_at[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (ndro_set)   begin set_t.push_back(cyc); exp_at.push_back(int'(exp_state)); end
            if (ndro_reset) begin rst_t.push_back(cyc); exp_at.push_back(int'(exp_state)); end
            if (ndro_clk)   begin clk_t.push_back(cyc); exp_at.push_back(int'(exp_state)); end
            if (int'(ndro_set) + int'(ndro_reset) + int'(ndro_clk) > 1) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] arg, output logic acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        acc       = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_cyc(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic clear_log();
        set_t.delete(); rst_t.delete(); clk_t.delete(); exp_at.delete();
    endtask

    initial begin
        logic acc;
        logic [5:0] accs;
        int k;
        logic [1:0] ops[5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
        int exp_seq[5] = '{1, 1, 0, 0, 0};

        // reset
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_pulses", {ndro_set, ndro_reset, ndro_clk}, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_counts", {read_count, err_count}, 0);
        chk("rst_mism_exp", {mismatch, exp_state}, 0);

        // back-to-back SET SET RESET RESET READ
        @(posedge clk); #1;
        clear_log();
        for (int i = 0; i < 5; i++) begin
            push(ops[i], 8'd0, acc);
            if (i == 0) k = cyc;
            chk("b2b_accept", acc, 1);
        end
        wait_idle(200);
        chk("b2b_nset", set_t.size(), 2);
        chk("b2b_nrst", rst_t.size(), 2);
        chk("b2b_nclk", clk_t.size(), 1);
        chk("b2b_set0", set_t[0], k + 2);
        chk("b2b_set1", set_t[1], k + 2 + GAP);
        chk("b2b_rst0", rst_t[0], k + 2 + 2 * GAP);
        chk("b2b_rst1", rst_t[1], k + 2 + 3 * GAP);
        chk("b2b_clk0", clk_t[0], k + 2 + 4 * GAP);
        for (int i = 0; i < 5; i++) chk("b2b_exp", exp_at[i], exp_seq[i]);
        chk("b2b_rdcnt", read_count, 1);
        chk("b2b_err", err_count, 0);
        chk("b2b_mism", mismatch, 0);

        // matching read with ndro_out high, then mismatching read with ndro_out low
        ndro_out = 1'b1;
        push(2'b01, 8'd0, acc);
        push(2'b11, 8'd0, acc);
        wait_idle(200);
        chk("rd1_cnt", read_count, 2);
        chk("rd1_err", err_count, 0);
        chk("rd1_mism", mismatch, 0);
        ndro_out = 1'b0;
        push(2'b01, 8'd0, acc);
        push(2'b11, 8'd0, acc);
        wait_idle(200);
        chk("rd2_cnt", read_count, 3);
        chk("rd2_err", err_count, 1);
        chk("rd2_mism", mismatch, 1);
        push(2'b10, 8'd0, acc);
        push(2'b11, 8'd0, acc);
        wait_idle(200);
        chk("rd3_cnt", read_count, 4);
        chk("rd3_err", err_count, 1);
        chk("rd3_mism", mismatch, 1);
        chk("rd3_exp", exp_state, 0);

        // FIFO full: 6 back-to-back pushes from idle
        for (int i = 0; i < 6; i++) begin
            push(2'b01, 8'd0, acc);
            if (i == 0) k = cyc;
            accs[i] = acc;
        end
        chk("full_accepts", accs, 6'b011111);
        wait_cyc(k + 1 + GAP);
        chk("full_ready_lo", cmd_ready, 0);
        wait_cyc(k + 2 + GAP);
        chk("full_ready_hi", cmd_ready, 1);
        wait_idle(300);

        // SET, WAIT 20, RESET
        clear_log();
        push(2'b01, 8'd0, acc);
        push(2'b00, 8'd20, acc);
        push(2'b10, 8'd0, acc);
        wait_idle(300);
        chk("wait_nset", set_t.size(), 1);
        chk("wait_nrst", rst_t.size(), 1);
        chk("wait_gap", rst_t[0] - set_t[0], 40);
        chk("wait_exp", exp_state, 0);

        // reset during slot cycle 4 of a SET
        push(2'b01, 8'd0, acc);
        k = cyc;
        push(2'b01, 8'd0, acc);
        push(2'b11, 8'd0, acc);
        wait_cyc(k + 3);
        chk("mid_exp_pre", exp_state, 1);
        wait_cyc(k + 5);
        reset_n = 1'b0;
        #1;
        chk("mid_outs", {ndro_set, ndro_reset, ndro_clk, exp_state, busy, mismatch}, 0);
        chk("mid_counts", {read_count, err_count}, 0);
        chk("mid_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_log();
        repeat (30) @(negedge clk);
        chk("post_pulses", set_t.size() + rst_t.size() + clk_t.size(), 0);
        chk("post_busy", busy, 0);
        chk("post_exp", exp_state, 0);
        chk("onehot_viol", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
